round_key_sequencer: RTL

ROUND_KEY_SEQUENCER -- requirements
Module: round_key_sequencer

---
 rtl/round_key_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/round_key_sequencer.sv
// Round-key sequencer: drives round indices to an external key-schedule
// generator, waits out the generator's fetch latency, and streams the 11
// round keys through a 2-entry FIFO in encrypt (0..10) or decrypt (10..0)
// order.
module round_key_sequencer #(
  parameter int FETCH_LAT = 2  // clk edges from kg_round_no update to kg_key capture, 1..4
) (
  input  logic         clk,
  input  logic         rest,
  input  logic         start,
  input  logic         dec_order,
  input  logic         kg_done,
  input  logic [127:0] kg_key,
  output logic [3:0]   kg_round_no,
  output logic [127:0] key_out,
  output logic [3:0]   key_idx,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         key_last,
  output logic         busy,
  output logic         seq_done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_KG,
    ISSUE,
    LATENCY,
    PUSH,
    DRAIN
  } state_t;

  localparam logic [1:0] LAT_LAST = 2'(FETCH_LAT - 1);

  state_t       state;
  logic [3:0]   idx;
  logic         dec_q;
  logic [1:0]   lat_cnt;

  // Two-slot FIFO; slot0 is always the head.
  logic [127:0] slot0_key;
  logic [127:0] slot1_key;
  logic [3:0]   slot0_idx;
  logic [3:0]   slot1_idx;
  logic [1:0]   count;

  logic [3:0]   final_idx;
  logic         push;
  logic         pop;

  assign final_idx = dec_q ? 4'd0 : 4'd10;
  assign key_valid = (count != 2'd0);
  assign key_out   = slot0_key;
  assign key_idx   = slot0_idx;
  assign key_last  = key_valid && (slot0_idx == final_idx);
  assign pop       = key_valid && key_ready;
  // A push may proceed into a full FIFO only when the head leaves the same cycle.
  assign push      = (state == PUSH) && ((count != 2'd2) || pop);

  // Sequence control: index stepping, generator handshake and status outputs.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state       <= IDLE;
      idx         <= 4'd0;
      dec_q       <= 1'b0;
      lat_cnt     <= 2'd0;
      kg_round_no <= 4'd0;
      busy        <= 1'b0;
      seq_done    <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all next-state terms read the pre-edge values.
      seq_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dec_q <= dec_order;
            idx   <= dec_order ? 4'd10 : 4'd0;
            busy  <= 1'b1;
            state <= WAIT_KG;
          end
        end
        WAIT_KG: begin
          if (kg_done) state <= ISSUE;
        end
        ISSUE: begin
          kg_round_no <= idx;
          lat_cnt     <= 2'd0;
          state       <= LATENCY;
        end
        LATENCY: begin
          if (lat_cnt == LAT_LAST) state <= PUSH;
          else                     lat_cnt <= lat_cnt + 2'd1;
        end
        PUSH: begin
          if (push) begin
            if (idx == final_idx) begin
              state <= DRAIN;
            end else begin
              idx   <= dec_q ? idx - 4'd1 : idx + 4'd1;
              state <= ISSUE;
            end
          end
        end
        DRAIN: begin
          if (pop && key_last) begin
            seq_done <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage: in-order push/pop with head kept in slot0.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      // NOTE: the data slots are reset too, since key_out/key_idx must read zero during reset.
      slot0_key <= '0;
      slot1_key <= '0;
      slot0_idx <= 4'd0;
      slot1_idx <= 4'd0;
      count     <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            slot0_key <= kg_key;
            slot0_idx <= idx;
          end else begin
            slot1_key <= kg_key;
            slot1_idx <= idx;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0_key <= slot1_key;
          slot0_idx <= slot1_idx;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0_key <= kg_key;
            slot0_idx <= idx;
          end else begin
            slot0_key <= slot1_key;
            slot0_idx <= slot1_idx;
            slot1_key <= kg_key;
            slot1_idx <= idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
